// File: rtl/svm_axil_master.sv
// svm_axil_master
//   AXI4-Lite initiator that drives the linear-SVM register block from a
//   streaming feature interface. One feature vector is taken per handshake.
//   For each vector the block does the following:
//     1. Writes every feature to 0x60+4k, sign-extended to the bus width.
//     2. Writes Control=0 and then Control=1, so Start always sees a
//        rising edge.
//     3. Polls Status until Done is set.
//     4. Reads Result and then Latency.
//   The decision is then presented on a valid/ready output.
//
// Ports
//   m_axi_aclk, m_axi_aresetn   clock; asynchronous active-low reset
//   in_valid/in_ready           feature-vector handshake
//   in_features_flat            feature k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   out_valid/out_ready         result handshake
//   out_decision                Result[DATA_WIDTH-1:0]
//   out_prediction              Status bit 2 from the final poll
//   out_latency                 Latency register
//   out_error                   error response (or poll timeout) during this vector
//   busy                        high whenever the state is not IDLE
//   m_axi_*                     AXI4-Lite master channels (AW, W, B, AR, R)
//
// Optional feature
//   SVM_AXIM_TIMEOUT_EN: bounds Status polling to TIMEOUT_POLLS reads.
//   When the bound is reached, the block soft-resets the slave and reports
//   out_error. When this macro is undefined, polling is unbounded and
//   TIMEOUT_POLLS has no effect.
module svm_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 8,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_FEATURES       = 16,
  parameter int DATA_WIDTH         = 16,
  parameter int TIMEOUT_POLLS      = 1024
) (
  input  logic                                 m_axi_aclk,
  input  logic                                 m_axi_aresetn,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_FEATURES*DATA_WIDTH-1:0]   in_features_flat,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_decision,
  output logic                                 out_prediction,
  output logic [31:0]                          out_latency,
  output logic                                 out_error,
  output logic                                 busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]        m_axi_awaddr,
  output logic [2:0]                           m_axi_awprot,
  output logic                                 m_axi_awvalid,
  input  logic                                 m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]        m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]      m_axi_wstrb,
  output logic                                 m_axi_wvalid,
  input  logic                                 m_axi_wready,
  input  logic [1:0]                           m_axi_bresp,
  input  logic                                 m_axi_bvalid,
  output logic                                 m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [2:0]                           m_axi_arprot,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                           m_axi_rresp,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_FEAT   = 4'd1;
  localparam logic [3:0] S_WR_CLR    = 4'd2;
  localparam logic [3:0] S_WR_START  = 4'd3;
  localparam logic [3:0] S_RD_STATUS = 4'd4;
  localparam logic [3:0] S_RD_RESULT = 4'd5;
  localparam logic [3:0] S_RD_LAT    = 4'd6;
  localparam logic [3:0] S_OUT       = 4'd7;
`ifdef SVM_AXIM_TIMEOUT_EN
  localparam logic [3:0] S_WR_SRST   = 4'd8;
  localparam logic [3:0] S_WR_SCLR   = 4'd9;
  localparam int         POLL_W      = $clog2(TIMEOUT_POLLS + 1);
`endif

  localparam logic [AW-1:0] A_CTRL   = AW'(32'h00);
  localparam logic [AW-1:0] A_STATUS = AW'(32'h04);
  localparam logic [AW-1:0] A_RESULT = AW'(32'h08);
  localparam logic [AW-1:0] A_LAT    = AW'(32'h0C);
  localparam logic [4:0]    LAST_IDX = 5'(NUM_FEATURES - 1);

  logic [3:0]                         state, nxt_state;
  logic [4:0]                         feat_idx;
  logic [NUM_FEATURES*DATA_WIDTH-1:0] feat_q;
  logic                               err_q, pred_q;
  logic [DATA_WIDTH-1:0]              dec_q;
  logic [31:0]                        lat_q;
  logic                               awvalid_q, wvalid_q, bwait_q, arvalid_q, rready_q;
  logic [AW-1:0]                      awaddr_q, araddr_q;
  logic [DW-1:0]                      wdata_q;
`ifdef SVM_AXIM_TIMEOUT_EN
  logic [POLL_W-1:0]                  poll_cnt;
`endif

  logic          b_hs, r_hs, accept;
  logic          launch_wr, launch_rd;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_data;

  function automatic logic [DATA_WIDTH-1:0] feature_at(
      input logic [NUM_FEATURES*DATA_WIDTH-1:0] flat, input logic [4:0] idx);
    return flat[idx*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [DW-1:0] sext_feature(input logic [DATA_WIDTH-1:0] f);
    logic signed [DATA_WIDTH-1:0] s;
    s = f;
    return DW'(s);
  endfunction

  function automatic logic [AW-1:0] feat_addr(input logic [4:0] idx);
    return AW'(32'h60 + (32'(idx) << 2));
  endfunction

  // Output decode. Handshakes count only while this block is waiting for them.
  assign in_ready       = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign out_valid      = (state == S_OUT);
  assign accept         = in_valid && in_ready;
  assign b_hs           = m_axi_bvalid && m_axi_bready;
  assign r_hs           = m_axi_rvalid && m_axi_rready;

  assign m_axi_awaddr   = awaddr_q;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awvalid  = awvalid_q;
  assign m_axi_wdata    = wdata_q;
  assign m_axi_wstrb    = '1;
  assign m_axi_wvalid   = wvalid_q;
  // B is accepted only after both the AW and W handshakes have retired.
  assign m_axi_bready   = bwait_q && !awvalid_q && !wvalid_q;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;

  assign out_decision   = dec_q;
  assign out_prediction = pred_q;
  assign out_latency    = lat_q;
  assign out_error      = err_q;

  // A completed response selects the next state and launches its transaction
  // in the same edge. This keeps exactly one transaction in flight.
  always_comb begin
    nxt_state = state;
    launch_wr = 1'b0;
    launch_rd = 1'b0;
    nxt_addr  = '0;
    nxt_data  = '0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          nxt_state = S_WR_FEAT;
          launch_wr = 1'b1;
          nxt_addr  = feat_addr(5'd0);
          nxt_data  = sext_feature(feature_at(in_features_flat, 5'd0));
        end
      end
      S_WR_FEAT: begin
        if (b_hs) begin
          launch_wr = 1'b1;
          if (feat_idx == LAST_IDX) begin
            nxt_state = S_WR_CLR;
            nxt_addr  = A_CTRL;
          end else begin
            nxt_addr  = feat_addr(feat_idx + 5'd1);
            nxt_data  = sext_feature(feature_at(feat_q, feat_idx + 5'd1));
          end
        end
      end
      S_WR_CLR: begin
        if (b_hs) begin
          nxt_state = S_WR_START;
          launch_wr = 1'b1;
          nxt_addr  = A_CTRL;
          nxt_data  = DW'(1);
        end
      end
      S_WR_START: begin
        if (b_hs) begin
          nxt_state = S_RD_STATUS;
          launch_rd = 1'b1;
          nxt_addr  = A_STATUS;
        end
      end
      S_RD_STATUS: begin
        if (r_hs) begin
          if (m_axi_rdata[0]) begin
            nxt_state = S_RD_RESULT;
            launch_rd = 1'b1;
            nxt_addr  = A_RESULT;
          end
`ifdef SVM_AXIM_TIMEOUT_EN
          else if (poll_cnt == POLL_W'(TIMEOUT_POLLS - 1)) begin
            nxt_state = S_WR_SRST;
            launch_wr = 1'b1;
            nxt_addr  = A_CTRL;
            nxt_data  = DW'(2);
          end
`endif
          else begin
            launch_rd = 1'b1;
            nxt_addr  = A_STATUS;
          end
        end
      end
      S_RD_RESULT: begin
        if (r_hs) begin
          nxt_state = S_RD_LAT;
          launch_rd = 1'b1;
          nxt_addr  = A_LAT;
        end
      end
      S_RD_LAT: begin
        if (r_hs) nxt_state = S_OUT;
      end
`ifdef SVM_AXIM_TIMEOUT_EN
      S_WR_SRST: begin
        if (b_hs) begin
          nxt_state = S_WR_SCLR;
          launch_wr = 1'b1;
          nxt_addr  = A_CTRL;
        end
      end
      S_WR_SCLR: begin
        if (b_hs) nxt_state = S_OUT;
      end
`endif
      S_OUT: begin
        if (out_ready) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state     <= S_IDLE;
      feat_idx  <= '0;
      feat_q    <= '0;
      err_q     <= 1'b0;
      pred_q    <= 1'b0;
      dec_q     <= '0;
      lat_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bwait_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
`ifdef SVM_AXIM_TIMEOUT_EN
      poll_cnt  <= '0;
`endif
    end else begin
      state <= nxt_state;

      // Address and data valids retire independently of each other.
      if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
      if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
      if (b_hs)                       bwait_q   <= 1'b0;
      if (arvalid_q && m_axi_arready) begin
        arvalid_q <= 1'b0;
        rready_q  <= 1'b1;
      end
      if (r_hs) rready_q <= 1'b0;

      if (launch_wr) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        bwait_q   <= 1'b1;
        awaddr_q  <= nxt_addr;
        wdata_q   <= nxt_data;
      end
      if (launch_rd) begin
        arvalid_q <= 1'b1;
        araddr_q  <= nxt_addr;
      end

      // The error flag is sticky for the whole vector.
      if ((b_hs && m_axi_bresp != 2'b00) || (r_hs && m_axi_rresp != 2'b00))
        err_q <= 1'b1;

      if (accept) begin
        feat_q   <= in_features_flat;
        feat_idx <= '0;
        err_q    <= 1'b0;
`ifdef SVM_AXIM_TIMEOUT_EN
        poll_cnt <= '0;
`endif
      end

      if (state == S_WR_FEAT && b_hs) feat_idx <= feat_idx + 5'd1;

      if (state == S_RD_STATUS && r_hs) begin
        if (m_axi_rdata[0]) pred_q <= m_axi_rdata[2];
`ifdef SVM_AXIM_TIMEOUT_EN
        poll_cnt <= poll_cnt + POLL_W'(1);
`endif
      end
      if (state == S_RD_RESULT && r_hs) dec_q <= m_axi_rdata[DATA_WIDTH-1:0];
      if (state == S_RD_LAT && r_hs)    lat_q <= m_axi_rdata[31:0];

`ifdef SVM_AXIM_TIMEOUT_EN
      // An abandoned inference reports a zeroed result, flagged as an error.
      if (state == S_WR_SCLR && b_hs) begin
        dec_q  <= '0;
        lat_q  <= '0;
        pred_q <= 1'b0;
        err_q  <= 1'b1;
      end
`endif
    end
  end

endmodule
